// File: rtl/psrn_pkg.sv
// Shared definitions for the psrn 16-bit hybrid rule-90/150 generator and checker.
package psrn_pkg;

  localparam logic [15:0] PSRN_SEED = 16'h00a3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } psrn_state_t;

  function automatic logic [15:0] psrn_next(input logic [15:0] s);
    logic [15:0] n;
    n[15] = s[15] ^ s[14];
    n[14] = s[15] ^ s[14] ^ s[13];
    n[13] = s[14] ^ s[12];
    n[12] = s[13] ^ s[12] ^ s[11];
    n[11] = s[12] ^ s[11] ^ s[10];
    n[10] = s[11] ^ s[9];
    n[9]  = s[10] ^ s[9]  ^ s[8];
    n[8]  = s[9]  ^ s[8]  ^ s[7];
    n[7]  = s[8]  ^ s[6];
    n[6]  = s[7]  ^ s[6]  ^ s[5];
    n[5]  = s[6]  ^ s[5]  ^ s[4];
    n[4]  = s[5]  ^ s[3];
    n[3]  = s[4]  ^ s[3]  ^ s[2];
    n[2]  = s[3]  ^ s[2]  ^ s[1];
    n[1]  = s[2]  ^ s[0];
    n[0]  = s[1]  ^ s[0];
    return n;
  endfunction

  function automatic logic [15:0] psrn_bitrev(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  function automatic logic [4:0] psrn_popcnt(input logic [15:0] w);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) c = c + 5'(w[i]);
    return c;
  endfunction

endpackage

// File: rtl/psrn_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment-by-amt; a clear
// coincident with an increment leaves the counter at amt.
module psrn_sat_cnt #(
  parameter int W  = 16,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  input  logic [AW-1:0] amt,
  output logic [W-1:0]  cnt
);

  logic [W:0] sum;

  assign sum = {1'b0, cnt} + (W+1)'(amt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= inc ? W'(amt) : '0;
    end else if (inc) begin
      cnt <= sum[W] ? {W{1'b1}} : sum[W-1:0];
    end
  end

endmodule

// File: rtl/psrn_chk.sv
// Self-synchronising checker for the psrn sequence: HUNT/VERIFY/LOCKED with flywheel.
// Optional per-bit error accumulator enabled by defining PSRN_CHK_BITERR_EN.
module psrn_chk
  import psrn_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] word_count
`ifdef PSRN_CHK_BITERR_EN
  ,
  output logic [ERR_W-1:0] bit_err_count
`endif
);

  psrn_state_t state, state_nxt;
  logic [15:0] pred, pred_nxt, pred_adv, exp_word;
  logic [3:0]  match_cnt, match_nxt;
  logic [3:0]  bad_cnt, bad_nxt, bad_eff;
  logic        hit, err_hit, word_hit;

  assign pred_adv = psrn_next(pred);
  assign exp_word = psrn_bitrev(pred_adv);
  assign hit      = (in_data == exp_word);
  // clear takes effect before this edge's error is added to the bad run
  assign bad_eff  = clear ? 4'd0 : bad_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pred_nxt  = pred;
    match_nxt = match_cnt;
    bad_nxt   = bad_eff;
    err_hit   = 1'b0;
    word_hit  = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (in_data != 16'h0000) begin
            pred_nxt  = psrn_bitrev(in_data);
            match_nxt = 4'd0;
            state_nxt = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            pred_nxt = pred_adv;
            if (match_cnt + 4'd1 == 4'(LOCK_CNT)) begin
              match_nxt = 4'd0;
              bad_nxt   = 4'd0;
              state_nxt = LOCKED;
            end else begin
              match_nxt = match_cnt + 4'd1;
            end
          end else begin
            match_nxt = 4'd0;
            if (in_data == 16'h0000) state_nxt = HUNT;
            else                     pred_nxt  = psrn_bitrev(in_data);
          end
        end
        LOCKED: begin
          word_hit = 1'b1;
          pred_nxt = pred_adv;
          if (hit) begin
            bad_nxt = 4'd0;
          end else begin
            err_hit = 1'b1;
            if (bad_eff + 4'd1 == 4'(UNLOCK_CNT)) begin
              bad_nxt   = 4'd0;
              state_nxt = HUNT;
            end else begin
              bad_nxt = bad_eff + 4'd1;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred      <= 16'h0000;
      match_cnt <= 4'd0;
      bad_cnt   <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      pred      <= pred_nxt;
      match_cnt <= match_nxt;
      bad_cnt   <= bad_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_hit;
    end
  end

  psrn_sat_cnt #(.W(ERR_W), .AW(5)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (err_hit),
    .amt   (5'd1),
    .cnt   (err_count)
  );

  psrn_sat_cnt #(.W(ERR_W), .AW(5)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (word_hit),
    .amt   (5'd1),
    .cnt   (word_count)
  );

`ifdef PSRN_CHK_BITERR_EN
  logic [4:0] bit_diff;

  assign bit_diff = psrn_popcnt(in_data ^ exp_word);

  psrn_sat_cnt #(.W(ERR_W), .AW(5)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .inc   (err_hit),
    .amt   (bit_diff),
    .cnt   (bit_err_count)
  );
`endif

endmodule

// File: tb/tb_psrn_chk.sv
// Directed bench for psrn_chk: table of per-word vectors plus gap/clear/reset sequences.
module tb_psrn_chk;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [15:0] word_count;
`ifdef PSRN_CHK_BITERR_EN
  logic [15:0] bit_err_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psrn_chk #(.LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .word_count (word_count)
`ifdef PSRN_CHK_BITERR_EN
    ,
    .bit_err_count (bit_err_count)
`endif
  );

  // Generator model: rule 150 on cells in 16'hDB6D, rule 90 elsewhere, null boundaries.
  logic [15:0] g = 16'h00a3;

  function automatic logic [15:0] brev(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[15-i] = w[i];
    return r;
  endfunction

  function automatic logic [15:0] gen_word();
    g = (g << 1) ^ (g >> 1) ^ (g & 16'hDB6D);
    return brev(g);
  endfunction

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        clr;
    logic        e_lock;
    logic        e_pulse;
    logic [15:0] e_err;
    logic [15:0] e_wc;
    logic [15:0] e_bit;
  } vec_t;

  vec_t tbl[40];
  int   ntbl = 0;

  task automatic add(input logic v, input logic [15:0] d, input logic lk, input logic pl,
                     input logic [15:0] er, input logic [15:0] wc, input logic [15:0] bt);
    tbl[ntbl] = '{v, d, 1'b0, lk, pl, er, wc, bt};
    ntbl++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic c);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic lk, input logic pl,
                         input logic [15:0] er, input logic [15:0] wc, input logic [15:0] bt);
    chk({tag, "_locked"}, locked, lk);
    chk({tag, "_pulse"}, err_pulse, pl);
    chk({tag, "_err"}, err_count, er);
    chk({tag, "_wc"}, word_count, wc);
`ifdef PSRN_CHK_BITERR_EN
    chk({tag, "_bit"}, bit_err_count, bt);
`else
    if (bt === 16'hffff) chk({tag, "_bitarg"}, 32'd0, 32'd1);
`endif
  endtask

  initial begin
    logic [15:0] w;
    int exp_err, exp_wc, exp_bit;

    // Zero words: ignored in HUNT
    for (int i = 0; i < 10; i++) add(1, 16'h0000, 0, 0, 0, 0, 0);
    // Clean lock: 5th word locks, it is not counted as a locked word
    for (int i = 0; i < 4; i++) add(1, gen_word(), 0, 0, 0, 0, 0);
    add(1, gen_word(), 1, 0, 0, 0, 0);
    add(1, gen_word(), 1, 0, 0, 1, 0);
    add(1, gen_word(), 1, 0, 0, 2, 0);
    add(1, gen_word(), 1, 0, 0, 3, 0);
    // Single error on bit 0, then flywheel match
    add(1, gen_word() ^ 16'h0001, 1, 1, 1, 4, 1);
    add(1, gen_word(), 1, 0, 1, 5, 1);
    // Three consecutive errors drop lock on the third
    add(1, gen_word() ^ 16'h0100, 1, 1, 2, 6, 2);
    add(1, gen_word() ^ 16'h0003, 1, 1, 3, 7, 4);
    add(1, gen_word() ^ 16'h8000, 0, 1, 4, 8, 5);
    add(0, 16'hdead, 0, 0, 4, 8, 5);
    // Relock after 5 clean words
    for (int i = 0; i < 4; i++) add(1, gen_word(), 0, 0, 4, 8, 5);
    add(1, gen_word(), 1, 0, 4, 8, 5);
    add(1, gen_word(), 1, 0, 4, 9, 5);

    rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < ntbl; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].e_lock, tbl[i].e_pulse,
              tbl[i].e_err, tbl[i].e_wc, tbl[i].e_bit);
    end

    // Random gaps while locked
    exp_wc = 9;
    for (int i = 0; i < 12; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int j = 0; j < gap; j++) begin
        step(0, 16'h5a5a, 0);
        chk("gap_pulse", err_pulse, 0);
        chk("gap_hold_wc", word_count, exp_wc);
      end
      w = gen_word();
      step(1, w, 0);
      exp_wc++;
      chk("gap_locked", locked, 1);
      chk("gap_wc", word_count, exp_wc);
      chk("gap_err", err_count, 4);
    end

    // Clear coincident with an error: counters end at 1
    w = gen_word() ^ 16'h0001;
    step(1, w, 1);
    chk_all("clr_err", 1, 1, 1, 1, 1);

    // Alternate good/error words up to err_count = 7, last word an error
    exp_err = 1; exp_wc = 1; exp_bit = 1;
    for (int i = 0; i < 6; i++) begin
      w = gen_word();
      step(1, w, 0);
      exp_wc++;
      w = gen_word() ^ 16'h0001;
      step(1, w, 0);
      exp_wc++; exp_err++; exp_bit++;
    end
    chk_all("pre_rst", 1, 1, 7, 16'(exp_wc), 16'(exp_bit));

    // Asynchronous reset mid-cycle
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, gen_word(), 0);
      chk("relock_early", locked, 0);
    end
    step(1, gen_word(), 0);
    chk_all("relock", 1, 0, 0, 0, 0);
    step(1, gen_word(), 0);
    chk_all("relock_wc", 1, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
